fetch_unit: RTL and testbench

- Instruction fetch stage that produces the 4-bit opcode stream consumed by the instruction decoder / control unit.
- Owns the program counter and issues single-outstanding requests to instruction memory over a req/ack interface.
- Presents each fetched instruction downstream with a valid/ready handshake.
- Handles early jump redirection (opcode 4'b1011) locally and accepts a redirect from execute for taken branches.

---
 rtl/fetch_unit.sv | 73 +++++++
 tb/tb_fetch_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and
// holds each fetched word for a valid/ready handshake; resolves jumps locally, redirect has priority.
module fetch_unit #(
  parameter int ADDR_W   = 8,
  parameter int INSTR_W  = 16,
  parameter int RESET_PC = 0
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [3:0]         opcode,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [3:0]        OP_JUMP  = 4'b1011;
  localparam logic [ADDR_W-1:0] PC_RESET = ADDR_W'(RESET_PC);

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic [3:0]        rdata_op;

  assign rdata_op = imem_rdata[INSTR_W-1 -: 4];

  // Outputs are pure state decodes so neither imem_ack nor instr_ready reach them combinationally.
  assign imem_req    = (state == S_FETCH);
  assign instr_valid = (state == S_HOLD);
  assign imem_addr   = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      pc       <= PC_RESET;
      instr    <= '0;
      opcode   <= '0;
      instr_pc <= '0;
    end else if (redirect) begin
      // Any in-flight ack or pending handshake this cycle is dropped.
      pc    <= redirect_pc;
      state <= S_FETCH;
    end else begin
      case (state)
        S_IDLE: state <= S_FETCH;
        S_FETCH: begin
          if (imem_ack) begin
            instr    <= imem_rdata;
            opcode   <= rdata_op;
            instr_pc <= pc;
            state    <= S_HOLD;
            if (rdata_op == OP_JUMP) pc <= imem_rdata[ADDR_W-1:0];
            else                     pc <= pc + 1'b1;
          end
        end
        S_HOLD: begin
          if (instr_ready) state <= S_FETCH;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run against a transaction-level PC model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [3:0]  opcode;
  logic [7:0]  instr_pc;
  logic        redirect;
  logic [7:0]  redirect_pc;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .opcode(opcode), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = '0;
    tick(); tick();
    checks++;
    if ({imem_req, instr_valid, instr, opcode, instr_pc, imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_state: req=%b vld=%b instr=%h op=%h ipc=%h addr=%h, required all zero",
               imem_req, instr_valid, instr, opcode, instr_pc, imem_addr);
    end
    rst = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_c1: req=%b vld=%b, required 0 0", imem_req, instr_valid);
    end
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_c2: req=%b addr=%h vld=%b, required 1 00 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_zero_wait;
    imem_ack = 1'b1; imem_rdata = 16'h1234; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || opcode !== 4'h1 || instr_pc !== 8'h00 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL zero_wait_deliver: vld=%b instr=%h op=%h ipc=%h req=%b, required 1 1234 1 00 0",
               instr_valid, instr, opcode, instr_pc, imem_req);
    end
    tick();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      errors++;
      $display("FAIL zero_wait_next: vld=%b req=%b addr=%h, required 0 1 01", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_backpressure;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h01) begin
        errors++;
        $display("FAIL wait_addr_stable: cycle %0d req=%b addr=%h, required 1 01", i, imem_req, imem_addr);
      end
    end
    imem_ack = 1'b1; imem_rdata = 16'h5AA5; instr_ready = 1'b0;
    tick();
    // Stray acks while no request is outstanding must be ignored.
    imem_rdata = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h5AA5 || opcode !== 4'h5 || instr_pc !== 8'h01 || imem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: cycle %0d vld=%b instr=%h op=%h ipc=%h req=%b, required 1 5aa5 5 01 0",
                 i, instr_valid, instr, opcode, instr_pc, imem_req);
      end
      if (i < 3) tick();
    end
    imem_ack = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h02) begin
      errors++;
      $display("FAIL backpressure_release: vld=%b req=%b addr=%h, required 0 1 02", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_jump;
    redirect = 1'b1; redirect_pc = 8'h10;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h10) begin
      errors++;
      $display("FAIL jump_setup: req=%b addr=%h, required 1 10", imem_req, imem_addr);
    end
    imem_ack = 1'b1; imem_rdata = 16'hB040; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hB040 || opcode !== 4'hB || instr_pc !== 8'h10) begin
      errors++;
      $display("FAIL jump_deliver: vld=%b instr=%h op=%h ipc=%h, required 1 b040 b 10", instr_valid, instr, opcode, instr_pc);
    end
    tick();
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL jump_target: req=%b addr=%h vld=%b, required 1 40 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_redirect_ack;
    imem_ack = 1'b1; imem_rdata = 16'h2222; redirect = 1'b1; redirect_pc = 8'h80;
    tick();
    imem_ack = 1'b0; redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h80) begin
      errors++;
      $display("FAIL redirect_vs_ack: vld=%b req=%b addr=%h, required 0 1 80", instr_valid, imem_req, imem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0 || instr === 16'h2222) begin
      errors++;
      $display("FAIL redirect_no_capture: vld=%b instr=%h, required 0 and not 2222", instr_valid, instr);
    end
  endtask

  task automatic test_redirect_hold;
    imem_ack = 1'b1; imem_rdata = 16'h0111; instr_ready = 1'b0;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'h80) begin
      errors++;
      $display("FAIL redirect_hold_setup: vld=%b ipc=%h, required 1 80", instr_valid, instr_pc);
    end
    redirect = 1'b1; redirect_pc = 8'h33; instr_ready = 1'b1;
    tick();
    redirect = 1'b0; instr_ready = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h33) begin
      errors++;
      $display("FAIL redirect_in_hold: vld=%b req=%b addr=%h, required 0 1 33", instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap;
    redirect = 1'b1; redirect_pc = 8'hFF;
    tick();
    redirect = 1'b0;
    imem_ack = 1'b1; imem_rdata = 16'h3000; instr_ready = 1'b1;
    tick();
    imem_ack = 1'b0;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 8'hFF || opcode !== 4'h3) begin
      errors++;
      $display("FAIL wrap_deliver: vld=%b ipc=%h op=%h, required 1 ff 3", instr_valid, instr_pc, opcode);
    end
    tick();
    instr_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL wrap_addr: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid;
    redirect = 1'b1; redirect_pc = 8'h55;
    tick();
    redirect = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h55) begin
      errors++;
      $display("FAIL reset_mid_setup: req=%b addr=%h, required 1 55", imem_req, imem_addr);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({imem_req, instr_valid, instr, opcode, instr_pc, imem_addr} !== '0) begin
      errors++;
      $display("FAIL reset_mid: req=%b vld=%b instr=%h op=%h ipc=%h addr=%h, required all zero",
               imem_req, instr_valid, instr, opcode, instr_pc, imem_addr);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_restart: req=%b addr=%h, required 1 00", imem_req, imem_addr);
    end
  endtask

  // Transaction model: next fetch address is the redirect target, the jump target, or pc+1 mod 256.
  task automatic test_random;
    logic [7:0]  mpc;
    logic [15:0] data;
    int          delivered;
    delivered = 0;
    mpc = 8'($urandom);
    redirect = 1'b1; redirect_pc = mpc;
    tick();
    redirect = 1'b0;
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== mpc || instr_valid !== 1'b0) begin
        errors++;
        $display("FAIL rand_req t%0d: req=%b addr=%h vld=%b, required 1 %h 0", t, imem_req, imem_addr, instr_valid, mpc);
      end
      data = 16'($urandom);
      if ($urandom_range(0, 3) == 0) data[15:12] = 4'hB;
      imem_ack = 1'b1; imem_rdata = data; instr_ready = 1'b0;
      if ($urandom_range(0, 7) == 0) begin
        mpc = 8'($urandom);
        redirect = 1'b1; redirect_pc = mpc;
        tick();
        imem_ack = 1'b0; redirect = 1'b0;
        checks++;
        if (instr_valid !== 1'b0) begin
          errors++;
          $display("FAIL rand_redirect_ack t%0d: vld=%b, required 0", t, instr_valid);
        end
        continue;
      end
      tick();
      imem_ack = 1'b0;
      for (int s = 0; s <= int'($urandom_range(0, 2)); s++) begin
        checks++;
        if (instr_valid !== 1'b1 || instr !== data || opcode !== data[15:12] || instr_pc !== mpc || imem_req !== 1'b0) begin
          errors++;
          $display("FAIL rand_deliver t%0d: vld=%b instr=%h op=%h ipc=%h req=%b, required 1 %h %h %h 0",
                   t, instr_valid, instr, opcode, instr_pc, imem_req, data, data[15:12], mpc);
        end
        if (s > 0) tick();
        else if ($urandom_range(0, 1) == 1) tick();
      end
      if (data[15:12] == 4'hB) mpc = data[7:0];
      else                     mpc = mpc + 8'd1;
      instr_ready = 1'b1;
      if ($urandom_range(0, 5) == 0) begin
        mpc = 8'($urandom);
        redirect = 1'b1; redirect_pc = mpc;
      end else begin
        delivered++;
      end
      tick();
      instr_ready = 1'b0; redirect = 1'b0;
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1) begin
        errors++;
        $display("FAIL rand_handoff t%0d: vld=%b req=%b, required 0 1", t, instr_valid, imem_req);
      end
    end
    checks++;
    if (delivered == 0) begin
      errors++;
      $display("FAIL rand_coverage: delivered=%0d, required > 0", delivered);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_backpressure();
    test_jump();
    test_redirect_ack();
    test_redirect_hold();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
